// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// memory-handshake FSM states and counter widths.
package pipe_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MEM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_W-1:0] rs_addrD, rt_addrD;
  logic [REG_W-1:0] rs_addrE, rt_addrE, r3_addrE;
  logic             RegWriteE, MemtoRegE, branch_takenE;
  logic [REG_W-1:0] r3_addrM;
  logic             RegWriteM, MemtoRegM, MemWriteM;
  logic [REG_W-1:0] r3_addrW;
  logic             RegWriteW;
  logic             mem_ready, stat_clr;

  logic             stallF, stallD, stallE, hold_EM;
  logic             flushD, flushE;
  logic [1:0]       fwdAE, fwdBE;
  logic             mem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_addrD, rt_addrD, rs_addrE, rt_addrE, r3_addrE,
           RegWriteE, MemtoRegE, branch_takenE,
           r3_addrM, RegWriteM, MemtoRegM, MemWriteM,
           r3_addrW, RegWriteW, mem_ready, stat_clr,
    input  stallF, stallD, stallE, hold_EM, flushD, flushE,
           fwdAE, fwdBE, mem_req, mem_err, stall_cnt
  );

  modport slave (
    input  rs_addrD, rt_addrD, rs_addrE, rt_addrE, r3_addrE,
           RegWriteE, MemtoRegE, branch_takenE,
           r3_addrM, RegWriteM, MemtoRegM, MemWriteM,
           r3_addrW, RegWriteW, mem_ready, stat_clr,
    output stallF, stallD, stallE, hold_EM, flushD, flushE,
           fwdAE, fwdBE, mem_req, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one EX source; the M stage has priority over W,
// and a load result in M is never forwarded (it is not available yet).
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             reg_write_m,
  input  logic             mem_to_reg_m,
  input  logic [REG_W-1:0] dst_m,
  input  logic             reg_write_w,
  input  logic [REG_W-1:0] dst_w,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && !mem_to_reg_m && (dst_m != '0) && (dst_m == src))
      sel = FWD_M;
    else if (reg_write_w && (dst_w != '0) && (dst_w == src))
      sel = FWD_W;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// the data-memory wait handshake with timeout and stall statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  fwd_sel_t         fwd_a, fwd_b;
  state_t           state_q, state_d;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_err_q;
  logic             mem_op, req_raw, timeout;
  logic             lw_stall, mem_stall, stall_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  pipe_fwd_unit u_fwd_a (
    .src          (hz.rs_addrE),
    .reg_write_m  (hz.RegWriteM),
    .mem_to_reg_m (hz.MemtoRegM),
    .dst_m        (hz.r3_addrM),
    .reg_write_w  (hz.RegWriteW),
    .dst_w        (hz.r3_addrW),
    .sel          (fwd_a)
  );

  pipe_fwd_unit u_fwd_b (
    .src          (hz.rt_addrE),
    .reg_write_m  (hz.RegWriteM),
    .mem_to_reg_m (hz.MemtoRegM),
    .dst_m        (hz.r3_addrM),
    .reg_write_w  (hz.RegWriteW),
    .dst_w        (hz.r3_addrW),
    .sel          (fwd_b)
  );

  assign mem_op = hz.MemtoRegM | hz.MemWriteM;

  // On timeout the access is abandoned: the request drops, so the stall releases.
  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_raw = 1'b1;
          if (!hz.mem_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'(MEM_TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          req_raw = 1'b1;
          if (hz.mem_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall = req_raw & ~hz.mem_ready;
  assign lw_stall  = hz.MemtoRegE & hz.RegWriteE & (hz.r3_addrE != '0) &
                     ((hz.r3_addrE == hz.rs_addrD) | (hz.r3_addrE == hz.rt_addrD));
  assign stall_any = mem_stall | lw_stall;

  // Outputs are gated by rst_n so reset silences them within the same cycle.
  assign hz.stallF    = rst_n & stall_any;
  assign hz.stallD    = rst_n & stall_any;
  assign hz.stallE    = rst_n & mem_stall;
  assign hz.hold_EM   = rst_n & mem_stall;
  assign hz.flushD    = rst_n & ~mem_stall & hz.branch_takenE;
  assign hz.flushE    = rst_n & ~mem_stall & (hz.branch_takenE | lw_stall);
  assign hz.fwdAE     = rst_n ? fwd_a : FWD_RF;
  assign hz.fwdBE     = rst_n ? fwd_b : FWD_RF;
  assign hz.mem_req   = rst_n & req_raw;
  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && !hz.mem_ready && !timeout)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
      if (timeout)
        mem_err_q <= 1'b1;
      if (hz.stat_clr)
        stall_cnt_q <= '0;
      else if (stall_any)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

endmodule
